// File: rtl/obstacle_spawn_scheduler_pkg.sv
// rtl/obstacle_spawn_scheduler_pkg.sv - shared types and LFSR step for the obstacle spawn scheduler
package obstacle_spawn_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    SPAWN = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CACTUS_S = 2'd0,
    CACTUS_L = 2'd1,
    BIRD_LO  = 2'd2,
    BIRD_HI  = 2'd3
  } spawn_type_e;

  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {1'b0, cur[7:1]} ^ (cur[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/obstacle_spawn_scheduler_if.sv
// rtl/obstacle_spawn_scheduler_if.sv - spawn request handshake between scheduler and renderer
interface obstacle_spawn_scheduler_if;
  import obstacle_spawn_scheduler_pkg::*;

  logic        spawn_valid;
  logic        spawn_ready;
  spawn_type_e spawn_type;

  modport master (output spawn_valid, output spawn_type, input spawn_ready);
  modport slave  (input spawn_valid, input spawn_type, output spawn_ready);

endinterface

// File: rtl/obstacle_spawn_scheduler_lfsr.sv
// rtl/obstacle_spawn_scheduler_lfsr.sv - free-running 8-bit Galois LFSR supplying type and jitter bits
module obstacle_spawn_scheduler_lfsr
  import obstacle_spawn_scheduler_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] lfsr_type,
  output logic [4:0] lfsr_jit
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr_type = lfsr_q[7:6];
  assign lfsr_jit  = lfsr_q[4:0];

endmodule

// File: rtl/obstacle_spawn_scheduler.sv
// rtl/obstacle_spawn_scheduler.sv - speed-scaled, jittered obstacle spawn sequencer with valid/ready output
module obstacle_spawn_scheduler
  import obstacle_spawn_scheduler_pkg::*;
#(
  parameter int         CNT_W         = 9,
  parameter int         BASE_INTERVAL = 400,
  parameter int         MIN_INTERVAL  = 64,
  parameter int         SPEED_STEP    = 24,
  parameter int         SPEED_W       = 4,
  parameter bit         JITTER_EN     = 1'b1,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick,
  input  logic                        start,
  input  logic                        pause,
  input  logic                        game_over,
  input  logic [SPEED_W-1:0]          speed,
  obstacle_spawn_scheduler_if.master  spawn_if,
  output logic [CNT_W-1:0]            count,
  output logic [7:0]                  spawns_total,
  output logic                        busy
);

  localparam int AW = CNT_W + SPEED_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  spawn_type_e      type_q, type_d;
  logic [7:0]       total_q, total_d;

  logic [1:0]       lfsr_type;
  logic [4:0]       lfsr_jit;

  logic signed [AW-1:0] raw_iv, base_iv, jit_iv;
  logic [CNT_W-1:0]     interval;

  obstacle_spawn_scheduler_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .lfsr_type (lfsr_type),
    .lfsr_jit  (lfsr_jit)
  );

  // Signed so a high speed can drive raw below zero before the floor is applied
  always_comb begin
    raw_iv  = AW'(BASE_INTERVAL) - AW'(speed) * AW'(SPEED_STEP);
    base_iv = (raw_iv < AW'(MIN_INTERVAL)) ? AW'(MIN_INTERVAL) : raw_iv;
    jit_iv  = base_iv + (JITTER_EN ? $signed(AW'(lfsr_jit)) : AW'(0));
    if (jit_iv > $signed(AW'(CNT_MAX))) interval = CNT_MAX;
    else                                interval = jit_iv[CNT_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    valid_d = valid_q;
    type_d  = type_q;
    total_d = total_q;
    unique case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        count_d = interval;
        state_d = COUNT;
      end
      COUNT: begin
        if (count_q == '0) begin
          state_d = SPAWN;
          valid_d = 1'b1;
          type_d  = spawn_type_e'(lfsr_type);
        end else if (tick && !pause) begin
          count_d = count_q - CNT_W'(1);
        end
      end
      SPAWN: begin
        if (spawn_if.spawn_ready) begin
          valid_d = 1'b0;
          total_d = total_q + 8'd1;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over start and over a same-cycle handshake
    if (game_over) begin
      state_d = IDLE;
      count_d = '0;
      valid_d = 1'b0;
      total_d = total_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      valid_q <= 1'b0;
      type_q  <= CACTUS_S;
      total_q <= 8'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      valid_q <= valid_d;
      type_q  <= type_d;
      total_q <= total_d;
    end
  end

  assign spawn_if.spawn_valid = valid_q;
  assign spawn_if.spawn_type  = type_q;
  assign count                = count_q;
  assign spawns_total         = total_q;
  assign busy                 = (state_q != IDLE);

endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// tb/tb_obstacle_spawn_scheduler.sv - scoreboard bench for obstacle_spawn_scheduler
module tb_obstacle_spawn_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       start_a, pause_a, go_a;
  logic [3:0] speed_a;
  logic       start_b, pause_b, go_b;
  logic [3:0] speed_b;
  logic [8:0] count_a, count_b;
  logic [7:0] total_a, total_b;
  logic       busy_a, busy_b;

  obstacle_spawn_scheduler_if if_a ();
  obstacle_spawn_scheduler_if if_b ();

  always #5 clk = ~clk;

  obstacle_spawn_scheduler #(.JITTER_EN(1'b0)) dut_a (
    .clk(clk), .rst(rst), .tick(tick), .start(start_a), .pause(pause_a),
    .game_over(go_a), .speed(speed_a), .spawn_if(if_a),
    .count(count_a), .spawns_total(total_a), .busy(busy_a)
  );

  obstacle_spawn_scheduler #(.BASE_INTERVAL(500), .JITTER_EN(1'b1)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .start(start_b), .pause(pause_b),
    .game_over(go_b), .speed(speed_b), .spawn_if(if_b),
    .count(count_b), .spawns_total(total_b), .busy(busy_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  int cyc     = 0;
  int rst_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) rst_cyc <= cyc + 1;
  end

  function automatic logic [7:0] lfsr_at(input int k);
    logic [7:0] v;
    v = 8'hA5;
    for (int i = 0; i < k - rst_cyc; i++) v = {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
    return v;
  endfunction

  typedef struct {
    int         cyc;
    logic [1:0] typ;
  } spawn_exp_t;

  spawn_exp_t exp_q[$];
  int         exp_total  = 0;
  logic       prev_valid = 1'b0;
  logic       prev_hs    = 1'b0;

  task automatic push_spawns(input int load_cyc, input int n, input int k);
    spawn_exp_t e;
    logic [7:0] v;
    int lc;
    for (int i = 0; i < k; i++) begin
      lc    = load_cyc + i * (n + 3);
      v     = lfsr_at(lc + 1 + n);
      e.cyc = lc + 2 + n;
      e.typ = v[7:6];
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin : mon_a
    spawn_exp_t e;
    if (rst) begin
      prev_valid <= 1'b0;
      prev_hs    <= 1'b0;
    end else begin
      if (prev_hs) check_eq("valid_drop", if_a.spawn_valid, 0);
      if (if_a.spawn_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("spawn_unexpected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check_eq("spawn_cyc", cyc, e.cyc);
          check_eq("spawn_type", if_a.spawn_type, e.typ);
          check_eq("spawn_total", total_a, exp_total);
          exp_total <= exp_total + 1;
        end
      end
      prev_valid <= if_a.spawn_valid;
      prev_hs    <= if_a.spawn_valid && if_a.spawn_ready;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_pulse_a(output int lc);
    start_a = 1'b1;
    lc      = cyc + 1;
    step();
    start_a = 1'b0;
  endtask

  task automatic abort_a();
    go_a = 1'b1;
    step();
    go_a = 1'b0;
    check_eq("abort_busy", busy_a, 0);
    check_eq("abort_count", count_a, 0);
  endtask

  task automatic wait_q_empty(input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      step();
      i++;
    end
    check_eq("q_drained", exp_q.size(), 0);
  endtask

  initial begin : stim
    int lc, lc2, i;
    logic [7:0] v;
    logic [1:0] t4_typ;

    rst = 1'b1; tick = 1'b1; start_a = 1'b1; pause_a = 1'b1; go_a = 1'b0; speed_a = 4'd7;
    start_b = 1'b1; pause_b = 1'b0; go_b = 1'b1; speed_b = 4'd3;
    if_a.spawn_ready = 1'b1; if_b.spawn_ready = 1'b0;

    // Reset dominates toggling inputs
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_valid", if_a.spawn_valid, 0);
      check_eq("rst_count", count_a, 0);
      check_eq("rst_busy", busy_a, 0);
      check_eq("rst_total", total_a, 0);
      check_eq("rst_lfsr", dut_a.u_lfsr.lfsr_q, 8'hA5);
      tick = ~tick; start_a = ~start_a; go_a = ~go_a; if_a.spawn_ready = ~if_a.spawn_ready;
    end
    rst = 1'b0; tick = 1'b1; start_a = 1'b0; pause_a = 1'b0; go_a = 1'b0; speed_a = 4'd0;
    start_b = 1'b0; go_b = 1'b0; speed_b = 4'd0; if_a.spawn_ready = 1'b1;
    step();
    check_eq("idle_busy", busy_a, 0);

    // Speed 0: interval 400, period 403
    start_pulse_a(lc);
    push_spawns(lc, 400, 2);
    check_eq("load_busy", busy_a, 1);
    step();
    check_eq("count_400", count_a, 400);
    wait_q_empty(1000);
    step();
    check_eq("total_2", total_a, 2);
    abort_a();

    // Speed 15: raw 40 floors to 64
    speed_a = 4'd15;
    start_pulse_a(lc);
    push_spawns(lc, 64, 3);
    step();
    check_eq("count_64", count_a, 64);
    wait_q_empty(300);
    step();
    check_eq("total_5", total_a, 5);
    abort_a();

    // Back-pressure in SPAWN
    if_a.spawn_ready = 1'b0;
    start_pulse_a(lc);
    push_spawns(lc, 64, 1);
    v = lfsr_at(lc + 65);
    t4_typ = v[7:6];
    wait_q_empty(200);
    for (int k = 0; k < 10; k++) begin
      check_eq("hold_valid", if_a.spawn_valid, 1);
      check_eq("hold_type", if_a.spawn_type, t4_typ);
      check_eq("hold_count", count_a, 0);
      step();
    end
    if_a.spawn_ready = 1'b1;
    step();
    check_eq("hs_valid", if_a.spawn_valid, 0);
    check_eq("hs_total", total_a, 6);
    step();
    check_eq("reload_count", count_a, 64);
    abort_a();

    // Pause and tick gating
    speed_a = 4'd0;
    start_pulse_a(lc);
    i = 0;
    while (count_a != 9'd200 && i < 500) begin
      step();
      i++;
    end
    check_eq("reach_200", count_a, 200);
    pause_a = 1'b1;
    repeat (50) step();
    check_eq("pause_hold", count_a, 200);
    pause_a = 1'b0;
    tick    = 1'b0;
    repeat (3) step();
    check_eq("tick_gate", count_a, 200);
    tick = 1'b1;
    step();
    check_eq("resume_199", count_a, 199);
    abort_a();

    // Saturating interval with maximal jitter, then abort from SPAWN
    if_b.spawn_ready = 1'b0;
    i = 0;
    v = lfsr_at(cyc + 1);
    while (v[4:0] != 5'd31 && i < 300) begin
      step();
      v = lfsr_at(cyc + 1);
      i++;
    end
    start_b = 1'b1;
    lc      = cyc + 1;
    step();
    start_b = 1'b0;
    check_eq("b_busy", busy_b, 1);
    step();
    check_eq("b_sat_511", count_b, 511);
    i = 0;
    while (!if_b.spawn_valid && i < 600) begin
      step();
      i++;
    end
    check_eq("b_spawn_cyc", cyc, lc + 513);
    v = lfsr_at(lc + 512);
    check_eq("b_spawn_type", if_b.spawn_type, v[7:6]);
    go_b = 1'b1; start_b = 1'b1; if_b.spawn_ready = 1'b1;
    step();
    check_eq("go_valid", if_b.spawn_valid, 0);
    check_eq("go_busy", busy_b, 0);
    check_eq("go_count", count_b, 0);
    check_eq("go_total", total_b, 0);
    go_b = 1'b0;
    lc2  = cyc + 1;
    step();
    start_b = 1'b0;
    check_eq("restart_busy", busy_b, 1);
    step();
    v = lfsr_at(lc2);
    check_eq("restart_count", count_b, (500 + int'(v[4:0]) > 511) ? 511 : 500 + int'(v[4:0]));
    go_b = 1'b1;
    step();
    go_b = 1'b0;
    check_eq("b_idle", busy_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
